// File: rtl/pwm_sample_sequencer_if.sv
// Sample-fetch handshake between the PWM sequencer and the sample table.
// The master (sequencer) raises smp_req with a stable smp_addr; the slave
// answers with a one-cycle smp_ack carrying smp_data.
interface pwm_sample_sequencer_if #(
  parameter int unsigned CNT_W  = 12,
  parameter int unsigned ADDR_W = 10
);
  logic              smp_req;
  logic [ADDR_W-1:0] smp_addr;
  logic              smp_ack;
  logic [CNT_W-1:0]  smp_data;

  modport master (output smp_req, output smp_addr, input smp_ack, input smp_data);
  modport slave  (input smp_req, input smp_addr, output smp_ack, output smp_data);
endinterface

// File: rtl/pwm_sample_sequencer.sv
// Sine-table PWM sequencer: owns the period counter, fetches duty samples
// over a req/ack handshake and double-buffers them so every duty change
// lands on a period boundary. A stop always finishes the running period.
module pwm_sample_sequencer #(
  parameter int unsigned CNT_W   = 12,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned TAB_LEN = 200
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [CNT_W-1:0]       top,
  pwm_sample_sequencer_if.master smp,
  output logic [CNT_W-1:0]       cont,
  output logic [CNT_W-1:0]       duty,
  output logic                   saida,
  output logic                   wrap,
  output logic                   underrun,
  output logic                   busy
);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cont_q, cont_d;
  logic [CNT_W-1:0]    duty_q, duty_d;
  logic [CNT_W-1:0]    shadow_q, shadow_d;
  logic                shadow_vld_q, shadow_vld_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    top_q, top_d;
  logic                underrun_q, underrun_d;
  logic                req_q, req_d;

  logic                active;
  logic                wrap_w;
  logic                ack_ok;
  logic [ADDR_W-1:0]   addr_inc;

  assign active   = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign wrap_w   = active && (cont_q == top_q);
  assign ack_ok   = req_q && smp.smp_ack;
  assign addr_inc = (addr_q == ADDR_W'(TAB_LEN - 1)) ? '0 : addr_q + 1'b1;

  // State register and all datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cont_q       <= '0;
      duty_q       <= '0;
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
      addr_q       <= '0;
      top_q        <= '0;
      underrun_q   <= 1'b0;
      req_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cont_q       <= cont_d;
      duty_q       <= duty_d;
      shadow_q     <= shadow_d;
      shadow_vld_q <= shadow_vld_d;
      addr_q       <= addr_d;
      top_q        <= top_d;
      underrun_q   <= underrun_d;
      req_q        <= req_d;
    end
  end

  // Next-state, counter, sample buffering and request generation
  always_comb begin
    state_d      = state_q;
    cont_d       = cont_q;
    duty_d       = duty_q;
    shadow_d     = shadow_q;
    shadow_vld_d = shadow_vld_q;
    addr_d       = addr_q;
    top_d        = top_q;
    underrun_d   = underrun_q;
    req_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        cont_d = '0;
        if (en) begin
          state_d      = S_PRIME;
          addr_d       = '0;
          underrun_d   = 1'b0;
          top_d        = top;
          shadow_vld_d = 1'b0;
        end
      end
      S_PRIME: begin
        cont_d = '0;
        if (!en) begin
          state_d = S_IDLE;
        end else if (ack_ok) begin
          duty_d  = smp.smp_data;
          addr_d  = addr_inc;
          state_d = S_RUN;
        end
      end
      S_RUN, S_DRAIN: begin
        cont_d = wrap_w ? '0 : cont_q + 1'b1;
        // An ack can only arrive while the shadow is empty, so an ack in the
        // wrap cycle fills the shadow while the wrap still counts as underrun.
        if (ack_ok) begin
          shadow_d     = smp.smp_data;
          shadow_vld_d = 1'b1;
          addr_d       = addr_inc;
        end
        if (wrap_w) begin
          top_d = top;
          if (shadow_vld_q) begin
            duty_d       = shadow_q;
            shadow_vld_d = 1'b0;
          end else begin
            underrun_d = 1'b1;
          end
        end
        if (en)                             state_d = S_RUN;
        else if (state_q == S_DRAIN && wrap_w) state_d = S_IDLE;
        else                                state_d = S_DRAIN;
      end
      default: state_d = S_IDLE;
    endcase

    // Request is registered: recomputed from the next state and dropped for
    // one cycle after every accepted ack.
    req_d = (state_d == S_PRIME) ||
            (((state_d == S_RUN) || (state_d == S_DRAIN)) && !shadow_vld_d);
    if (ack_ok) req_d = 1'b0;
  end

  assign smp.smp_req  = req_q;
  assign smp.smp_addr = addr_q;
  assign cont         = cont_q;
  assign duty         = duty_q;
  assign saida        = active && (cont_q < duty_q);
  assign wrap         = wrap_w;
  assign underrun     = underrun_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_pwm_sample_sequencer.sv
// Directed bench for pwm_sample_sequencer: a per-cycle vector table for
// start-up, prefetch, underrun and address wrap, then hand-written
// sequences for drain, duty extremes, top=0, mid-run reset and top change.
module tb_pwm_sample_sequencer;
  localparam int unsigned CW = 12;
  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic [CW-1:0] top = '0;
  logic [CW-1:0] cont, duty;
  logic          saida, wrap, underrun, busy;

  pwm_sample_sequencer_if #(.CNT_W(CW), .ADDR_W(AW)) bus ();

  pwm_sample_sequencer #(.CNT_W(CW), .ADDR_W(AW), .TAB_LEN(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .top     (top),
    .smp     (bus.master),
    .cont    (cont),
    .duty    (duty),
    .saida   (saida),
    .wrap    (wrap),
    .underrun(underrun),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          en;
    logic [CW-1:0] top;
    logic          ack;
    logic [CW-1:0] data;
    logic [38:0]   exp;
  } vec_t;

  vec_t vq[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [38:0] o(logic r, logic [AW-1:0] a, logic [CW-1:0] c,
                                    logic [CW-1:0] d, logic s, logic w, logic u, logic b);
    return {r, a, c, d, s, w, u, b};
  endfunction

  function automatic void add(logic e, logic ak, logic [CW-1:0] dt, logic [38:0] ex);
    vec_t v;
    v.en = e; v.top = 12'd9; v.ack = ak; v.data = dt; v.exp = ex;
    vq.push_back(v);
  endfunction

  function automatic logic [38:0] outs();
    return {bus.smp_req, bus.smp_addr, cont, duty, saida, wrap, underrun, busy};
  endfunction

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", n, a, e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; bus.smp_ack = 1'b0; bus.smp_data = '0;
    cyc();
    rst = 1'b0;
  endtask

  // Start from IDLE: raise en, ack the first request with d.
  task automatic prime(logic [CW-1:0] t, logic [CW-1:0] d);
    en = 1'b1; top = t;
    cyc();
    chk("prime_req", {63'd0, bus.smp_req}, 64'd1);
    bus.smp_ack = 1'b1; bus.smp_data = d;
    cyc();
    bus.smp_ack = 1'b0;
    chk("prime_duty", {52'd0, duty}, {52'd0, d});
  endtask

  task automatic wait_cont(logic [CW-1:0] t);
    int n = 0;
    while (cont !== t && n < 40) begin cyc(); n++; end
    chk("wait_cont", {52'd0, cont}, {52'd0, t});
  endtask

  // Ack every request with d and expect a constant saida level.
  task automatic run_level(int n, logic [CW-1:0] d, logic s, string nm);
    for (int i = 0; i < n; i++) begin
      bus.smp_ack = bus.smp_req; bus.smp_data = d;
      chk(nm, {63'd0, saida}, {63'd0, s});
      cyc();
    end
    bus.smp_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    bus.smp_ack = 1'b0; bus.smp_data = '0;

    // Start-up, prefetch, ignored stray ack, underrun, late fill, addr wrap
    add(1, 0, 0,  o(0, 0, 0, 0, 0, 0, 0, 0));
    add(1, 1, 3,  o(1, 0, 0, 0, 0, 0, 0, 1));
    add(1, 1, 50, o(0, 1, 0, 3, 1, 0, 0, 1));
    add(1, 1, 5,  o(1, 1, 1, 3, 1, 0, 0, 1));
    add(1, 0, 0,  o(0, 2, 2, 3, 1, 0, 0, 1));
    for (int c = 3; c <= 8; c++) add(1, 0, 0, o(0, 2, 12'(c), 3, 0, 0, 0, 1));
    add(1, 0, 0,  o(0, 2, 9, 3, 0, 1, 0, 1));
    for (int c = 0; c <= 9; c++) add(1, 0, 0, o(1, 2, 12'(c), 5, c < 5, c == 9, 0, 1));
    add(1, 1, 7,  o(1, 2, 0, 5, 1, 0, 1, 1));
    for (int c = 1; c <= 8; c++) add(1, 0, 0, o(0, 3, 12'(c), 5, c < 5, 0, 1, 1));
    add(1, 0, 0,  o(0, 3, 9, 5, 0, 1, 1, 1));
    add(1, 1, 9,  o(1, 3, 0, 7, 1, 0, 1, 1));
    add(1, 0, 0,  o(0, 0, 1, 7, 1, 0, 1, 1));

    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    for (int i = 0; i < vq.size(); i++) begin
      en = vq[i].en; top = vq[i].top; bus.smp_ack = vq[i].ack; bus.smp_data = vq[i].data;
      chk($sformatf("row%0d", i), {25'd0, outs()}, {25'd0, vq[i].exp});
      cyc();
    end
    bus.smp_ack = 1'b0;

    // Stop at cont=4 completes the period
    wait_cont(4);
    en = 1'b0;
    cyc();
    chk("drain_busy", {63'd0, busy}, 64'd1);
    wait_cont(9);
    chk("drain_wrap", {63'd0, wrap}, 64'd1);
    cyc();
    chk("drain_idle", {61'd0, busy, saida, bus.smp_req}, 64'd0);
    chk("drain_cont", {52'd0, cont}, 64'd0);

    // Restart clears underrun and address; re-raise en during drain
    prime(9, 2);
    chk("restart_addr", {54'd0, bus.smp_addr}, 64'd1);
    chk("restart_und", {63'd0, underrun}, 64'd0);
    wait_cont(4);
    en = 1'b0;
    cyc(); cyc();
    en = 1'b1;
    wait_cont(9);
    chk("nostop_wrap", {63'd0, wrap}, 64'd1);
    cyc();
    chk("nostop_busy", {63'd0, busy}, 64'd1);

    // Duty extremes
    do_reset();
    prime(4, 0);
    run_level(12, 0, 1'b0, "duty0");
    do_reset();
    prime(4, 5);
    run_level(12, 5, 1'b1, "duty_top1");

    // top=0 -> wrap every cycle
    do_reset();
    prime(0, 1);
    for (int i = 0; i < 4; i++) begin
      chk("top0_wrap", {51'd0, wrap, cont}, {51'd0, 1'b1, 12'd0});
      cyc();
    end

    // Reset during RUN with an outstanding request
    do_reset();
    prime(9, 3);
    cyc();
    chk("pre_rst_req", {63'd0, bus.smp_req}, 64'd1);
    rst = 1'b1;
    cyc();
    chk("mid_rst", {25'd0, outs()}, 64'd0);
    rst = 1'b0; en = 1'b0;

    // top change mid-period takes effect after the next wrap
    prime(9, 3);
    wait_cont(3);
    top = 12'd4;
    wait_cont(9);
    chk("old_top_wrap", {63'd0, wrap}, 64'd1);
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk("new_top_nowrap", {63'd0, wrap}, 64'd0);
      cyc();
    end
    chk("new_top_wrap", {51'd0, wrap, cont}, {51'd0, 1'b1, 12'd4});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
